// File: rtl/gpio_reg_arb.sv
// gpio_reg_arb
//   Two-master round-robin arbiter in front of a single GPIO register slave.
//   A request from either master is granted one cycle later. The access
//   fields are latched on grant and held on the slave bus until the slave
//   acks. The ack is then forwarded combinationally to the granted master.
//
//   Optional feature macro: GPIO_ARB_TIMEOUT_EN. When it is defined, an
//   access that sees no slave ack within TOUT_CYCLES cycles completes with
//   err=1 and rdata=32'hDEAD_DEAD.
//
// Ports
//   mclk, h_reset          clock, synchronous active-high reset
//   mN_reg_cs/wr/addr/     master N request (N=0,1)
//     wdata/be
//   mN_reg_rdata/ack/err   master N completion (ack is a one-cycle pulse)
//   s_reg_cs/wr/addr/      registered slave-side request
//     wdata/be
//   s_reg_rdata/ack        slave completion
module gpio_reg_arb #(
  parameter int TOUT_CYCLES = 255
) (
  input  logic        mclk,
  input  logic        h_reset,
  input  logic        m0_reg_cs,
  input  logic        m0_reg_wr,
  input  logic [3:0]  m0_reg_addr,
  input  logic [31:0] m0_reg_wdata,
  input  logic [3:0]  m0_reg_be,
  output logic [31:0] m0_reg_rdata,
  output logic        m0_reg_ack,
  output logic        m0_reg_err,
  input  logic        m1_reg_cs,
  input  logic        m1_reg_wr,
  input  logic [3:0]  m1_reg_addr,
  input  logic [31:0] m1_reg_wdata,
  input  logic [3:0]  m1_reg_be,
  output logic [31:0] m1_reg_rdata,
  output logic        m1_reg_ack,
  output logic        m1_reg_err,
  output logic        s_reg_cs,
  output logic        s_reg_wr,
  output logic [3:0]  s_reg_addr,
  output logic [31:0] s_reg_wdata,
  output logic [3:0]  s_reg_be,
  input  logic [31:0] s_reg_rdata,
  input  logic        s_reg_ack
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t r_state, w_next;
  logic   r_last_gnt;
  // Set if the granted master lets go of cs mid-access. The slave access
  // still runs to completion, but nothing is returned to the master.
  logic   r_drop;
  logic   w_gnt0, w_gnt1;
  logic   w_tout, w_done;
  logic   w_ack0, w_ack1;

`ifdef GPIO_ARB_TIMEOUT_EN
  logic [7:0] r_tcnt;

  always_ff @(posedge mclk) begin
    if (h_reset)                   r_tcnt <= '0;
    else if (w_gnt0 || w_gnt1)     r_tcnt <= '0;
    else if (r_state != IDLE && !s_reg_ack) r_tcnt <= r_tcnt + 8'd1;
  end

  assign w_tout = (r_state != IDLE) && (r_tcnt == 8'(TOUT_CYCLES - 1));
`else
  assign w_tout = 1'b0;
`endif

  // The slave ack takes priority, so err is reported only for a pure timeout.
  assign w_done = s_reg_ack || w_tout;

  always_comb begin
    w_next = r_state;
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    case (r_state)
      IDLE: begin
        if (m0_reg_cs && m1_reg_cs) begin
          w_gnt0 = r_last_gnt;
          w_gnt1 = !r_last_gnt;
        end else begin
          w_gnt0 = m0_reg_cs;
          w_gnt1 = m1_reg_cs;
        end
        if (w_gnt0)      w_next = GNT0;
        else if (w_gnt1) w_next = GNT1;
      end
      GNT0, GNT1: if (w_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (h_reset) begin
      r_state     <= IDLE;
      r_last_gnt  <= 1'b1;
      r_drop      <= 1'b0;
      s_reg_cs    <= 1'b0;
      s_reg_wr    <= 1'b0;
      s_reg_addr  <= '0;
      s_reg_wdata <= '0;
      s_reg_be    <= '0;
    end else begin
      r_state <= w_next;
      if (w_gnt0) begin
        s_reg_cs    <= 1'b1;
        s_reg_wr    <= m0_reg_wr;
        s_reg_addr  <= m0_reg_addr;
        s_reg_wdata <= m0_reg_wdata;
        s_reg_be    <= m0_reg_be;
        r_last_gnt  <= 1'b0;
        r_drop      <= 1'b0;
      end else if (w_gnt1) begin
        s_reg_cs    <= 1'b1;
        s_reg_wr    <= m1_reg_wr;
        s_reg_addr  <= m1_reg_addr;
        s_reg_wdata <= m1_reg_wdata;
        s_reg_be    <= m1_reg_be;
        r_last_gnt  <= 1'b1;
        r_drop      <= 1'b0;
      end else begin
        if (r_state != IDLE && w_done) s_reg_cs <= 1'b0;
        if ((r_state == GNT0 && !m0_reg_cs) || (r_state == GNT1 && !m1_reg_cs))
          r_drop <= 1'b1;
      end
    end
  end

  // Master-side completion is combinational from the slave ack.
  // It is gated off during reset and after the master drops cs.
  assign w_ack0 = !h_reset && (r_state == GNT0) && w_done && m0_reg_cs && !r_drop;
  assign w_ack1 = !h_reset && (r_state == GNT1) && w_done && m1_reg_cs && !r_drop;

  assign m0_reg_ack   = w_ack0;
  assign m1_reg_ack   = w_ack1;
  assign m0_reg_rdata = !w_ack0 ? 32'h0 : (s_reg_ack ? s_reg_rdata : 32'hDEAD_DEAD);
  assign m1_reg_rdata = !w_ack1 ? 32'h0 : (s_reg_ack ? s_reg_rdata : 32'hDEAD_DEAD);
`ifdef GPIO_ARB_TIMEOUT_EN
  assign m0_reg_err   = w_ack0 && !s_reg_ack;
  assign m1_reg_err   = w_ack1 && !s_reg_ack;
`else
  assign m0_reg_err   = 1'b0;
  assign m1_reg_err   = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_reg_arb.sv
module tb_gpio_reg_arb;

`ifdef GPIO_ARB_TIMEOUT_EN
  localparam int TOUT = 8;
`else
  localparam int TOUT = 255;
`endif

  logic        mclk = 1'b0;
  logic        h_reset;
  logic        m0_reg_cs, m0_reg_wr, m1_reg_cs, m1_reg_wr;
  logic [3:0]  m0_reg_addr, m0_reg_be, m1_reg_addr, m1_reg_be;
  logic [31:0] m0_reg_wdata, m1_reg_wdata;
  logic [31:0] m0_reg_rdata, m1_reg_rdata;
  logic        m0_reg_ack, m0_reg_err, m1_reg_ack, m1_reg_err;
  logic        s_reg_cs, s_reg_wr;
  logic [3:0]  s_reg_addr, s_reg_be;
  logic [31:0] s_reg_wdata, s_reg_rdata;
  logic        s_reg_ack;

  int n_chk = 0;
  int n_err = 0;

  always #5 mclk = ~mclk;

  gpio_reg_arb #(.TOUT_CYCLES(TOUT)) dut (
    .mclk(mclk), .h_reset(h_reset),
    .m0_reg_cs(m0_reg_cs), .m0_reg_wr(m0_reg_wr), .m0_reg_addr(m0_reg_addr),
    .m0_reg_wdata(m0_reg_wdata), .m0_reg_be(m0_reg_be),
    .m0_reg_rdata(m0_reg_rdata), .m0_reg_ack(m0_reg_ack), .m0_reg_err(m0_reg_err),
    .m1_reg_cs(m1_reg_cs), .m1_reg_wr(m1_reg_wr), .m1_reg_addr(m1_reg_addr),
    .m1_reg_wdata(m1_reg_wdata), .m1_reg_be(m1_reg_be),
    .m1_reg_rdata(m1_reg_rdata), .m1_reg_ack(m1_reg_ack), .m1_reg_err(m1_reg_err),
    .s_reg_cs(s_reg_cs), .s_reg_wr(s_reg_wr), .s_reg_addr(s_reg_addr),
    .s_reg_wdata(s_reg_wdata), .s_reg_be(s_reg_be),
    .s_reg_rdata(s_reg_rdata), .s_reg_ack(s_reg_ack)
  );

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int acks;
    int cs_low;
    h_reset = 1'b1;
    m0_reg_cs = 0; m0_reg_wr = 0; m0_reg_addr = 0; m0_reg_wdata = 0; m0_reg_be = 0;
    m1_reg_cs = 0; m1_reg_wr = 0; m1_reg_addr = 0; m1_reg_wdata = 0; m1_reg_be = 0;
    s_reg_rdata = 0; s_reg_ack = 0;
    tick(); tick();
    chk("rst_s_cs", s_reg_cs, 0);
    chk("rst_s_addr", s_reg_addr, 0);
    chk("rst_s_wdata", s_reg_wdata, 0);
    chk("rst_m0_ack", m0_reg_ack, 0);
    chk("rst_m1_ack", m1_reg_ack, 0);
    chk("rst_m0_rdata", m0_reg_rdata, 0);
    h_reset = 1'b0;
    tick();

    // slave ack while idle is ignored
    s_reg_ack = 1; s_reg_rdata = 32'h1111_2222; #1;
    chk("idle_ack_m0", m0_reg_ack, 0);
    chk("idle_ack_m1", m1_reg_ack, 0);
    tick();
    chk("idle_ack_s_cs", s_reg_cs, 0);
    s_reg_ack = 0;

    // m0 write, slave acks after two cycles
    m0_reg_cs = 1; m0_reg_wr = 1; m0_reg_addr = 4'h2; m0_reg_wdata = 32'h0000_00FF; m0_reg_be = 4'hF;
    #1;
    chk("wr_cs_pre", s_reg_cs, 0);
    tick();
    chk("wr_s_cs", s_reg_cs, 1);
    chk("wr_s_wr", s_reg_wr, 1);
    chk("wr_s_addr", s_reg_addr, 4'h2);
    chk("wr_s_wdata", s_reg_wdata, 32'h0000_00FF);
    chk("wr_s_be", s_reg_be, 4'hF);
    chk("wr_m0_ack_early", m0_reg_ack, 0);
    m0_reg_wdata = 32'hFFFF_0000; // stable while granted
    tick();
    chk("wr_s_wdata_hold", s_reg_wdata, 32'h0000_00FF);
    chk("wr_m0_ack_wait", m0_reg_ack, 0);
    s_reg_ack = 1; s_reg_rdata = 32'h0000_1234; #1;
    chk("wr_m0_ack", m0_reg_ack, 1);
    chk("wr_m0_err", m0_reg_err, 0);
    chk("wr_m1_ack", m1_reg_ack, 0);
    chk("wr_m1_rdata", m1_reg_rdata, 0);
    tick();
    s_reg_ack = 0; m0_reg_cs = 0; #1;
    chk("wr_s_cs_drop", s_reg_cs, 0);
    chk("wr_m0_ack_once", m0_reg_ack, 0);

    // m1 read
    m1_reg_cs = 1; m1_reg_wr = 0; m1_reg_addr = 4'h5; m1_reg_be = 4'hF;
    tick();
    chk("rd_s_cs", s_reg_cs, 1);
    chk("rd_s_wr", s_reg_wr, 0);
    chk("rd_s_addr", s_reg_addr, 4'h5);
    s_reg_ack = 1; s_reg_rdata = 32'hA5A5_5A5A; #1;
    chk("rd_m1_ack", m1_reg_ack, 1);
    chk("rd_m1_rdata", m1_reg_rdata, 32'hA5A5_5A5A);
    chk("rd_m0_ack", m0_reg_ack, 0);
    chk("rd_m0_rdata", m0_reg_rdata, 0);
    tick();
    s_reg_ack = 0; m1_reg_cs = 0; #1;
    chk("rd_m1_rdata_after", m1_reg_rdata, 0);
    chk("rd_m1_ack_after", m1_reg_ack, 0);

    // contention: last grant was m1, so m0 then m1, then m0 again
    m0_reg_cs = 1; m0_reg_addr = 4'h1; m1_reg_cs = 1; m1_reg_addr = 4'h3;
    tick();
    chk("rr1_s_addr", s_reg_addr, 4'h1);
    s_reg_ack = 1; #1;
    chk("rr1_m0_ack", m0_reg_ack, 1);
    chk("rr1_m1_ack", m1_reg_ack, 0);
    tick();
    s_reg_ack = 0; m0_reg_cs = 0; #1;
    chk("rr1_s_cs_gap", s_reg_cs, 0);
    tick();
    chk("rr2_s_cs", s_reg_cs, 1);
    chk("rr2_s_addr", s_reg_addr, 4'h3);
    s_reg_ack = 1; #1;
    chk("rr2_m1_ack", m1_reg_ack, 1);
    chk("rr2_m0_ack", m0_reg_ack, 0);
    tick();
    s_reg_ack = 0; m1_reg_cs = 0;
    tick();
    m0_reg_cs = 1; m1_reg_cs = 1;
    tick();
    chk("rr3_s_addr", s_reg_addr, 4'h1);
    s_reg_ack = 1; #1;
    chk("rr3_m0_ack", m0_reg_ack, 1);
    tick();
    s_reg_ack = 0; m0_reg_cs = 0; m1_reg_cs = 0;
    tick();

    // reset during GNT0 (last_gnt is now 0); reset must favour m0 again
    m0_reg_cs = 1; m0_reg_addr = 4'h7;
    tick();
    chk("rst_gnt_s_cs", s_reg_cs, 1);
    h_reset = 1; s_reg_ack = 1; #1;
    chk("rst_gnt_m0_ack", m0_reg_ack, 0);
    tick();
    chk("rst_gnt_s_cs_drop", s_reg_cs, 0);
    chk("rst_gnt_m0_ack2", m0_reg_ack, 0);
    h_reset = 0; s_reg_ack = 0;
    m0_reg_addr = 4'h6; m1_reg_cs = 1; m1_reg_addr = 4'h9;
    tick();
    chk("rst_rr_s_addr", s_reg_addr, 4'h6);
    s_reg_ack = 1; #1;
    chk("rst_rr_m0_ack", m0_reg_ack, 1);
    tick();
    s_reg_ack = 0; m0_reg_cs = 0;

    // m1 (still requesting) is granted, then drops cs before the ack
    tick();
    chk("drop_s_addr", s_reg_addr, 4'h9);
    m1_reg_cs = 0;
    tick();
    chk("drop_s_cs_held", s_reg_cs, 1);
    s_reg_ack = 1; s_reg_rdata = 32'hCAFE_F00D; #1;
    chk("drop_m1_ack", m1_reg_ack, 0);
    chk("drop_m1_rdata", m1_reg_rdata, 0);
    tick();
    s_reg_ack = 0; #1;
    chk("drop_s_cs_done", s_reg_cs, 0);

    // m0 access with no slave ack
    m0_reg_cs = 1; m0_reg_addr = 4'hC;
    tick();
    chk("to_s_cs", s_reg_cs, 1);
`ifdef GPIO_ARB_TIMEOUT_EN
    acks = 0;
    for (int k = 0; k < 7; k++) begin
      if (m0_reg_ack) acks++;
      tick();
    end
    chk("to_no_early_ack", acks, 0);
    chk("to_m0_ack", m0_reg_ack, 1);
    chk("to_m0_err", m0_reg_err, 1);
    chk("to_m0_rdata", m0_reg_rdata, 32'hDEAD_DEAD);
    tick();
    m0_reg_cs = 0; #1;
    chk("to_s_cs_drop", s_reg_cs, 0);
    chk("to_m0_ack_after", m0_reg_ack, 0);
`else
    acks = 0; cs_low = 0;
    for (int k = 0; k < 310; k++) begin
      if (m0_reg_ack) acks++;
      if (!s_reg_cs) cs_low++;
      tick();
    end
    chk("wait_no_ack", acks, 0);
    chk("wait_cs_held", cs_low, 0);
    chk("wait_err", m0_reg_err, 0);
    m0_reg_cs = 0; h_reset = 1;
    tick();
    h_reset = 0;
`endif
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
